// File: rtl/vx_writeback_seq.sv
// vx_writeback_seq: round-robin commit arbiter with packet lock and registered writeback beat.
// Optional perf counters are built when WB_SEQ_PERF_EN is defined.
module vx_writeback_seq #(
  parameter int NUM_INPUTS    = 4,
  parameter int WIS_W         = 2,
  parameter int REG_W         = 8,
  parameter int NUM_LANES     = 4,
  parameter int XLEN          = 32,
  parameter int UUID_W        = 44,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               in_valid,
  output logic [NUM_INPUTS-1:0]               in_ready,
  input  logic [NUM_INPUTS*WIS_W-1:0]         in_wis,
  input  logic [NUM_INPUTS*REG_W-1:0]         in_rd,
  input  logic [NUM_INPUTS*NUM_LANES-1:0]     in_tmask,
  input  logic [NUM_INPUTS*NUM_LANES*XLEN-1:0] in_data,
  input  logic [NUM_INPUTS*UUID_W-1:0]        in_uuid,
  input  logic [NUM_INPUTS-1:0]               in_sop,
  input  logic [NUM_INPUTS-1:0]               in_eop,
  output logic                                wb_valid,
  output logic [WIS_W-1:0]                    wb_wis,
  output logic [REG_W-1:0]                    wb_rd,
  output logic [NUM_LANES-1:0]                wb_tmask,
  output logic [NUM_LANES*XLEN-1:0]           wb_data,
  output logic [UUID_W-1:0]                   wb_uuid,
  output logic                                wb_sop,
  output logic                                wb_eop
`ifdef WB_SEQ_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]            perf_conflicts,
  output logic [PERF_CTR_BITS-1:0]            perf_lock_bubbles
`endif
);

  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int DATA_W = NUM_LANES * XLEN;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] sel_next;
  logic             accept;

  logic [WIS_W-1:0]     sel_wis;
  logic [REG_W-1:0]     sel_rd;
  logic [NUM_LANES-1:0] sel_tmask;
  logic [DATA_W-1:0]    sel_data;
  logic [UUID_W-1:0]    sel_uuid;
  logic                 sel_sop;
  logic                 sel_eop;

  // First requester at or after rr_ptr, wrapping around the channels.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!grant_found &&
          in_valid[(int'(rr_ptr) + k) % NUM_INPUTS]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_INPUTS);
      end
    end
  end

  // Ready is one-hot: the grant when idle, the owner only when locked.
  always_comb begin
    in_ready = '0;
    if (state == LOCKED) begin
      in_ready[owner] = in_valid[owner];
    end else if (grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign sel      = (state == LOCKED) ? owner : grant_idx;
  assign sel_next = IDX_W'((int'(sel) + 1) % NUM_INPUTS);
  assign accept   = |in_ready;

  assign sel_wis   = in_wis[int'(sel)*WIS_W +: WIS_W];
  assign sel_rd    = in_rd[int'(sel)*REG_W +: REG_W];
  assign sel_tmask = in_tmask[int'(sel)*NUM_LANES +: NUM_LANES];
  assign sel_data  = in_data[int'(sel)*DATA_W +: DATA_W];
  assign sel_uuid  = in_uuid[int'(sel)*UUID_W +: UUID_W];
  assign sel_sop   = in_sop[sel];
  assign sel_eop   = in_eop[sel];

  // Lock FSM, round-robin pointer and the registered writeback beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      wb_valid <= 1'b0;
      wb_wis   <= '0;
      wb_rd    <= '0;
      wb_tmask <= '0;
      wb_data  <= '0;
      wb_uuid  <= '0;
      wb_sop   <= 1'b0;
      wb_eop   <= 1'b0;
    end else begin
      wb_valid <= accept;
      if (accept) begin
        wb_wis   <= sel_wis;
        wb_rd    <= sel_rd;
        wb_tmask <= sel_tmask;
        wb_data  <= sel_data;
        wb_uuid  <= sel_uuid;
        wb_sop   <= sel_sop;
        wb_eop   <= sel_eop;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (sel_eop) begin
              rr_ptr <= sel_next;
            end else begin
              state <= LOCKED;
              owner <= sel;
            end
          end
        end
        LOCKED: begin
          if (accept && sel_eop) begin
            state  <= IDLE;
            rr_ptr <= sel_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_SEQ_PERF_EN
  logic conflict;
  logic lock_bubble;

  assign conflict    = |(in_valid & ~in_ready);
  assign lock_bubble = (state == LOCKED) && !in_valid[owner];

  // Free-running event counters; they wrap on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflicts    <= '0;
      perf_lock_bubbles <= '0;
    end else begin
      if (conflict) perf_conflicts <= perf_conflicts + 1'b1;
      if (lock_bubble) perf_lock_bubbles <= perf_lock_bubbles + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Flag protocol violations; the datapath still forwards the beat.
  always @(posedge clk) begin
    if (!reset && accept) begin
      if (state == IDLE) begin
        assert (sel_sop)
          else $error("packet start without sop on ch %0d", sel);
      end else begin
        assert (!sel_sop)
          else $error("sop inside locked packet on ch %0d", sel);
        assert (sel_wis == wb_wis && sel_rd == wb_rd)
          else $error("wis/rd changed inside packet on ch %0d", sel);
      end
    end
  end
`endif

endmodule
